// File: rtl/fil_pkg.sv
// Shared types and defaults for the filter-bank fill stage (fil_fill and fil_mem).
package fil_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_ADDR_W = 10;
  localparam int DIM_W      = 5;
  localparam int PROD_W     = 32;
  localparam int N_DIMS     = 6;

  localparam logic [2:0] CALC_LAST = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } fil_state_e;

  // A filter set must be non-empty and fit in the buffer.
  function automatic logic total_in_range(input logic [PROD_W-1:0] total,
                                          input logic [PROD_W-1:0] depth);
    return (total != {PROD_W{1'b0}}) && (total <= depth);
  endfunction

endpackage

// File: rtl/fil_fill_if.sv
// Valid/ready filter-word stream between the off-chip interface (master) and fil_fill (slave).
interface fil_fill_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/fil_mem.sv
// Filter buffer: one write port, one registered read port; out-of-range reads return zero.
module fil_mem
  import fil_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read sees the pre-write value on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if ({1'b0, raddr} < (ADDR_W+1)'(DEPTH)) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= {DATA_W{1'b0}};
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/fil_fill.sv
// Filter-bank fill stage: sizes a filter set from six dimensions, then streams it into fil_mem.
// Optional build macro FIL_FILL_CHKSUM_EN adds an XOR checksum output over accepted words.
module fil_fill
  import fil_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  oc,
  input  logic [DIM_W-1:0]  ic,
  input  logic [DIM_W-1:0]  icb,
  input  logic [DIM_W-1:0]  ocb,
  input  logic [DIM_W-1:0]  filter_height,
  input  logic [DIM_W-1:0]  filter_width,
  fil_fill_if.slave         s_if,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              full,
  output logic              done,
  output logic              cfg_err,
  output logic [ADDR_W:0]   wr_count
`ifdef FIL_FILL_CHKSUM_EN
  ,
  output logic [DATA_W-1:0] chksum
`endif
);

  fil_state_e        state_r, state_nxt_s;
  logic [2:0]        calc_idx_r;
  logic [DIM_W-1:0]  dims_r [N_DIMS];
  logic [PROD_W-1:0] total_r;
  logic [ADDR_W:0]   wr_count_r;
  logic              s_ready_r, busy_r, full_r, done_r, cfg_err_r;

  logic              start_ok_s, accept_s, last_word_s;
  logic [DIM_W-1:0]  dim_sel_s;
  logic [PROD_W-1:0] prod_s;

  assign start_ok_s  = start && ((state_r == IDLE) || (state_r == DONE));
  assign accept_s    = s_if.s_valid && s_ready_r;
  assign last_word_s = ({{(PROD_W-ADDR_W-1){1'b0}}, wr_count_r} + 32'd1) == total_r;
  assign prod_s      = total_r * {{(PROD_W-DIM_W){1'b0}}, dim_sel_s};

  // Dimension consumed by the current CALC step (ocb, oc, icb, ic, height, width).
  always_comb begin
    dim_sel_s = {DIM_W{1'b0}};
    case (calc_idx_r)
      3'd0:    dim_sel_s = dims_r[0];
      3'd1:    dim_sel_s = dims_r[1];
      3'd2:    dim_sel_s = dims_r[2];
      3'd3:    dim_sel_s = dims_r[3];
      3'd4:    dim_sel_s = dims_r[4];
      3'd5:    dim_sel_s = dims_r[5];
      default: dim_sel_s = {DIM_W{1'b0}};
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = state_r;
        end
      end
      CALC: begin
        if (calc_idx_r != CALC_LAST) begin
          state_nxt_s = CALC;
        end else if (total_in_range(prod_s, PROD_W'(DEPTH))) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FILL: begin
        if (accept_s && last_word_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = FILL;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      calc_idx_r <= 3'd0;
      total_r    <= {PROD_W{1'b0}};
      wr_count_r <= {(ADDR_W+1){1'b0}};
      s_ready_r  <= 1'b0;
      busy_r     <= 1'b0;
      full_r     <= 1'b0;
      done_r     <= 1'b0;
      cfg_err_r  <= 1'b0;
      for (int i = 0; i < N_DIMS; i++) begin
        dims_r[i] <= {DIM_W{1'b0}};
      end
    end else begin
      state_r   <= state_nxt_s;
      s_ready_r <= (state_nxt_s == FILL);
      busy_r    <= (state_nxt_s == CALC) || (state_nxt_s == FILL);
      done_r    <= (state_r == FILL) && accept_s && last_word_s;
      if (start_ok_s) begin
        dims_r[0]  <= ocb;
        dims_r[1]  <= oc;
        dims_r[2]  <= icb;
        dims_r[3]  <= ic;
        dims_r[4]  <= filter_height;
        dims_r[5]  <= filter_width;
        total_r    <= 32'd1;
        calc_idx_r <= 3'd0;
        cfg_err_r  <= 1'b0;
        full_r     <= 1'b0;
        wr_count_r <= {(ADDR_W+1){1'b0}};
      end else if (state_r == CALC) begin
        total_r    <= prod_s;
        calc_idx_r <= calc_idx_r + 3'd1;
        if ((calc_idx_r == CALC_LAST) && !total_in_range(prod_s, PROD_W'(DEPTH))) begin
          cfg_err_r <= 1'b1;
        end
      end else if (accept_s) begin
        wr_count_r <= wr_count_r + {{ADDR_W{1'b0}}, 1'b1};
        full_r     <= last_word_s;
      end
    end
  end

`ifdef FIL_FILL_CHKSUM_EN
  logic [DATA_W-1:0] chksum_r;

  // Running XOR of accepted words, restarted with each fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      chksum_r <= {DATA_W{1'b0}};
    end else if (start_ok_s) begin
      chksum_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      chksum_r <= chksum_r ^ s_if.s_data;
    end
  end

  assign chksum = chksum_r;
`endif

  fil_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (accept_s),
    .waddr (wr_count_r[ADDR_W-1:0]),
    .wdata (s_if.s_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign s_if.s_ready = s_ready_r;
  assign busy         = busy_r;
  assign full         = full_r;
  assign done         = done_r;
  assign cfg_err      = cfg_err_r;
  assign wr_count     = wr_count_r;

endmodule

// File: tb/tb_fil_fill.sv
// Self-checking bench for fil_fill: directed scenarios with random data/valid against a
// behavioural model (dimension product, array memory image, XOR checksum).
module tb_fil_fill;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [4:0]        oc, ic, icb, ocb, filter_height, filter_width;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy, full, done, cfg_err;
  logic [ADDR_W:0]   wr_count;
`ifdef FIL_FILL_CHKSUM_EN
  logic [DATA_W-1:0] chksum;
`endif

  fil_fill_if #(.DATA_W(DATA_W)) s_if ();

  fil_fill dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .oc            (oc),
    .ic            (ic),
    .icb           (icb),
    .ocb           (ocb),
    .filter_height (filter_height),
    .filter_width  (filter_width),
    .s_if          (s_if),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .busy          (busy),
    .full          (full),
    .done          (done),
    .cfg_err       (cfg_err),
    .wr_count      (wr_count)
`ifdef FIL_FILL_CHKSUM_EN
    ,
    .chksum        (chksum)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                known   [DEPTH];
  int                exp_total;
  int                accepted;
  logic [DATA_W-1:0] chk_model;
  logic [DATA_W-1:0] tbl [3];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_dims(input int a, input int b, input int c, input int d, input int e, input int f);
    ocb = 5'(a); oc = 5'(b); icb = 5'(c); ic = 5'(d); filter_height = 5'(e); filter_width = 5'(f);
  endtask

  // Pulse start, walk through the six sizing cycles and check the outcome.
  task automatic start_calc(output bit ok);
    exp_total = int'(ocb) * int'(oc) * int'(icb) * int'(ic) * int'(filter_height) * int'(filter_width);
    ok = (exp_total != 0) && (exp_total <= DEPTH);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("calc_busy", busy, 1);
    check("calc_full_clr", full, 0);
    check("calc_err_clr", cfg_err, 0);
    check("calc_wrcnt_clr", wr_count, 0);
    for (int i = 0; i < 6; i++) begin
      check("calc_ready_low", s_if.s_ready, 0);
      check("calc_done_low", done, 0);
      tick;
    end
    check("calc_end_ready", s_if.s_ready, ok);
    check("calc_end_busy", busy, ok);
    check("calc_end_err", cfg_err, !ok);
    accepted  = 0;
    chk_model = '0;
  endtask

  // vmode: 0 valid always, 1 every other cycle, 2 random. dmode: 0 counting, 1 random, 2 table.
  task automatic feed(input int stop_at, input int vmode, input int dmode, input bit rdchk, input int budget);
    int cyc = 0;
    while (accepted < stop_at && cyc < budget) begin
      bit                exp_rdy = (accepted < exp_total);
      bit                v, hs, old_known;
      logic [DATA_W-1:0] d, old;
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      case (dmode)
        0:       d = 16'(accepted + 1);
        1:       d = 16'($urandom);
        default: d = tbl[accepted % 3];
      endcase
      s_if.s_valid = v;
      s_if.s_data  = d;
      old_known    = known[accepted];
      old          = ref_mem[accepted];
      if (rdchk) rd_addr = 10'(accepted);
      check("fill_ready", s_if.s_ready, exp_rdy);
      hs = v && exp_rdy;
      tick;
      if (hs) begin
        ref_mem[accepted] = d;
        known[accepted]   = 1'b1;
        chk_model         = chk_model ^ d;
        accepted++;
      end
      check("fill_done", done, hs && (accepted == exp_total));
      check("fill_wrcnt", wr_count, accepted);
      check("fill_full", full, accepted == exp_total);
      if (rdchk && old_known) check("rd_collide_old", rd_data, old);
      cyc++;
    end
    s_if.s_valid = 1'b0;
    if (accepted < stop_at) check("fill_budget", accepted, stop_at);
  endtask

  // After completion, offered words must be refused and status must hold.
  task automatic after_done;
    for (int i = 0; i < 3; i++) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = 16'($urandom);
      check("done_ready_low", s_if.s_ready, 0);
      tick;
      check("done_pulse_once", done, 0);
      check("done_wrcnt_hold", wr_count, exp_total);
      check("done_full_hold", full, 1);
      check("done_busy_low", busy, 0);
    end
    s_if.s_valid = 1'b0;
`ifdef FIL_FILL_CHKSUM_EN
    check("chksum", chksum, chk_model);
`endif
  endtask

  task automatic readback(input int n);
    for (int a = 0; a < n; a++) begin
      rd_addr = 10'(a);
      tick;
      check("readback", rd_data, ref_mem[a]);
    end
  endtask

  initial begin
    bit ok;
    tbl[0] = 16'h00F0; tbl[1] = 16'h0F00; tbl[2] = 16'hF00F;
    rst = 1'b1; start = 1'b0; rd_addr = '0;
    s_if.s_valid = 1'b0; s_if.s_data = '0;
    set_dims(1, 1, 1, 1, 1, 1);
    repeat (3) tick;
    check("rst_ready", s_if.s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_done", done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_wrcnt", wr_count, 0);
    check("rst_rddata", rd_data, 0);
    rst = 1'b0;
    tick;
    check("idle_busy", busy, 0);

    // Basic 3x3 fill with counting data.
    set_dims(1, 1, 1, 1, 3, 3);
    start_calc(ok);
    feed(9, 0, 0, 1'b0, 40);
    after_done();
    readback(9);

    // Backpressure: valid toggles, total 12.
    set_dims(2, 1, 2, 1, 3, 1);
    start_calc(ok);
    feed(12, 1, 1, 1'b1, 60);
    after_done();
    readback(12);

    // Start during FILL is ignored, then start from DONE restarts at address 0.
    start_calc(ok);
    feed(4, 2, 1, 1'b1, 60);
    set_dims(0, 0, 0, 0, 0, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("ign_start_busy", busy, 1);
    check("ign_start_ready", s_if.s_ready, 1);
    check("ign_start_wrcnt", wr_count, 4);
    check("ign_start_err", cfg_err, 0);
    feed(12, 2, 1, 1'b1, 100);
    after_done();
    set_dims(2, 1, 2, 1, 3, 1);
    start_calc(ok);
    feed(12, 2, 1, 1'b1, 100);
    after_done();
    readback(12);

    // Checksum pattern: XOR of the three table words is 0xFFFF.
    set_dims(1, 1, 1, 1, 3, 1);
    start_calc(ok);
    feed(3, 0, 2, 1'b1, 20);
    check("chk_model_pattern", chk_model, 16'hFFFF);
    after_done();
    readback(3);

    // Configuration errors: zero dimension and oversize products.
    set_dims(1, 1, 1, 1, 3, 0);
    start_calc(ok);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("err_sticky", cfg_err, 1);
      check("err_ready_low", s_if.s_ready, 0);
      check("err_busy_low", busy, 0);
    end
    set_dims(31, 31, 1, 1, 2, 1);
    start_calc(ok);
    set_dims(2, 27, 19, 1, 1, 1);
    start_calc(ok);

    // Boundary totals: single word and exactly DEPTH words.
    set_dims(1, 1, 1, 1, 1, 1);
    start_calc(ok);
    feed(1, 0, 1, 1'b1, 10);
    after_done();
    readback(1);
    set_dims(4, 4, 4, 4, 4, 1);
    start_calc(ok);
    feed(DEPTH, 0, 1, 1'b0, DEPTH + 10);
    after_done();
    for (int i = 0; i < 16; i++) begin
      int a = (i == 0) ? DEPTH - 1 : int'($urandom_range(0, DEPTH - 1));
      rd_addr = 10'(a);
      tick;
      check("readback_full", rd_data, ref_mem[a]);
    end

    // Reset mid-fill, then a fresh fill.
    set_dims(2, 1, 2, 1, 3, 1);
    start_calc(ok);
    feed(5, 0, 1, 1'b0, 20);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_wrcnt", wr_count, 0);
    check("midrst_full", full, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", s_if.s_ready, 0);
    tick;
    check("midrst_idle_ready", s_if.s_ready, 0);
    start_calc(ok);
    feed(12, 2, 1, 1'b1, 100);
    after_done();
    readback(12);

    // Random dimensions.
    for (int r = 0; r < 6; r++) begin
      set_dims($urandom_range(1, 3), $urandom_range(0, 4), $urandom_range(1, 3),
               $urandom_range(1, 3), $urandom_range(0, 4), $urandom_range(1, 3));
      start_calc(ok);
      if (ok) begin
        feed(exp_total, 2, 1, 1'b1, 6 * exp_total + 20);
        after_done();
        readback((exp_total < 16) ? exp_total : 16);
      end else begin
        tick;
        check("rand_err_sticky", cfg_err, 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
